// File: rtl/conv_bitplane_driver.sv
// Bit-serial driver for the 4-input distributed-arithmetic conv kernel: streams activation
// bit-planes LSB first and shift-accumulates kernel output. Define CONV_SIGNED_EN for two's complement.
module conv_bitplane_driver #(
  parameter int DATA_W = 8,
  parameter int KOUT_W = 12,
  parameter int ACC_W  = KOUT_W + DATA_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DATA_W-1:0]   in_data,
  output logic [3:0]            kin,
  input  logic [KOUT_W-1:0]     kout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_W-1:0]      out_data,
  output logic                  busy
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  localparam logic [BW-1:0] LAST_PLANE = BW'(DATA_W - 1);

  logic [1:0]            state;
  logic [4*DATA_W-1:0]   act;
  logic [BW-1:0]         b;
  logic [ACC_W-1:0]      acc;

  logic [BW-1:0]         d;
  logic                  acc_en;
  logic [ACC_W-1:0]      kout_ext;
  logic [ACC_W-1:0]      term;
  logic [ACC_W-1:0]      acc_next;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == HOLD);
  assign busy      = (state != IDLE);
  assign out_data  = acc;
  assign kout_ext  = ACC_W'(kout);

  // kout lags kin by one cycle, so the plane being absorbed is b-1 in SHIFT and the last plane in DRAIN.
  always_comb begin
    d      = (state == DRAIN) ? LAST_PLANE : b - 1'b1;
    acc_en = ((state == SHIFT) && (b != '0)) || (state == DRAIN);
    term   = kout_ext << d;
`ifdef CONV_SIGNED_EN
    acc_next = (d == LAST_PLANE) ? acc - term : acc + term;
`else
    acc_next = acc + term;
`endif
  end

  always_comb begin
    kin = '0;
    if (state == SHIFT) begin
      for (int unsigned k = 0; k < 4; k++) begin
        kin[k] = act[k*DATA_W + int'(b)];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      act   <= '0;
      b     <= '0;
      acc   <= '0;
    end else begin
      if (acc_en) acc <= acc_next;
      case (state)
        IDLE: begin
          if (in_valid) begin
            act   <= in_data;
            acc   <= '0;
            b     <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (b == LAST_PLANE) begin
            b     <= '0;
            state <= DRAIN;
          end else begin
            b <= b + 1'b1;
          end
        end
        DRAIN: state <= HOLD;
        HOLD: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_bitplane_driver.sv
// Scoreboard bench for conv_bitplane_driver with a registered DA kernel stub
// (f(n) = n0 + 2*n1 + 3*n2 + 4*n3). Honours CONV_SIGNED_EN for the reference model.
module tb_conv_bitplane_driver;

  localparam int DW = 8;
  localparam int KW = 12;
  localparam int AW = KW + DW;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [4*DW-1:0] in_data;
  logic [3:0]    kin;
  logic [KW-1:0] kout;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_data;
  logic          busy;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  logic [AW-1:0] exp_q[$];

  conv_bitplane_driver #(.DATA_W(DW), .KOUT_W(KW), .ACC_W(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .kin       (kin),
    .kout      (kout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    kout <= KW'(int'(kin[0]) + 2*int'(kin[1]) + 3*int'(kin[2]) + 4*int'(kin[3]));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask

  function automatic logic [AW-1:0] model(input logic [4*DW-1:0] d);
    longint sum = 0;
    longint v;
    logic [DW-1:0] ak;
    for (int k = 0; k < 4; k++) begin
      ak = d[k*DW +: DW];
      v  = longint'(ak);
`ifdef CONV_SIGNED_EN
      if (ak[DW-1]) v = v - (longint'(1) << DW);
`endif
      sum += (k + 1) * v;
    end
    return sum[AW-1:0];
  endfunction

  function automatic logic [4*DW-1:0] pack(input int a0, input int a1, input int a2, input int a3);
    return {DW'(a3), DW'(a2), DW'(a1), DW'(a0)};
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      if (in_valid && in_ready) exp_q.push_back(model(in_data));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("result_unexpected", 64'd1, 64'd0);
        else check("result", 64'(out_data), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    if (!in_ready) check(tag, 64'd0, 64'd1);
  endtask

  task automatic run_op(input logic [4*DW-1:0] d);
    wait_idle("idle_timeout_pre");
    in_data  = d;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_idle("idle_timeout_post");
  endtask

  initial begin
    logic [4*DW-1:0] d;
    logic [3:0]      pl;
    logic [AW-1:0]   held;
    int t0, n, prev;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_kin", 64'(kin), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    step();

    // Test 1: kin planes, latency and value
    d = pack(1, 2, 3, 4);
    in_data  = d;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    t0 = cyc;
    for (int p = 0; p < DW; p++) begin
      for (int k = 0; k < 4; k++) pl[k] = d[k*DW + p];
      check($sformatf("t1_kin_p%0d", p), 64'(kin), 64'(pl));
      step();
    end
    check("t1_kin_drain", 64'(kin), 64'd0);
    n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    check("t1_latency", 64'(cyc - t0 + 1), 64'(DW + 2));
    check("t1_value", 64'(out_data), 64'd30);
    wait_idle("t1_idle");

    // Test 2/3: boundary values
`ifdef CONV_SIGNED_EN
    run_op(pack(255, 0, 0, 0));
    check("t3_minus1", 64'(out_data), 64'hFFFFF);
    run_op(pack(128, 0, 0, 1));
    check("t3_minus124", 64'(out_data), 64'(AW'(-124)));
`else
    run_op(pack(255, 255, 255, 255));
    check("t2_max", 64'(out_data), 64'd2550);
`endif
    run_op(pack(0, 0, 0, 0));
    check("zero", 64'(out_data), 64'd0);

    // Test 4: backpressure in HOLD
    out_ready = 1'b0;
    in_data   = pack(10, 20, 30, 40);
    in_valid  = 1'b1;
    step();
    in_valid  = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    held = out_data;
    check("t4_value", 64'(held), 64'd300);
    for (int i = 0; i < 5; i++) begin
      in_data  = pack(i + 1, 7, 7, 7);
      in_valid = 1'b1;
      step();
      check("t4_valid", 64'(out_valid), 64'd1);
      check("t4_stable", 64'(out_data), 64'(held));
      check("t4_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check("t4_idle", 64'(busy), 64'd0);
    check("t4_valid_low", 64'(out_valid), 64'd0);

    // Test 5: reset mid-SHIFT
    in_data  = pack(9, 9, 9, 9);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("t5_kin", 64'(kin), 64'd0);
    check("t5_out_valid", 64'(out_valid), 64'd0);
    check("t5_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    step();
    run_op(pack(1, 2, 3, 4));
    check("t5_after", 64'(out_data), 64'd30);

    // Test 6: back-to-back with in_valid and out_ready high
    in_valid = 1'b1;
    in_data  = 32'($urandom);
    prev = -1;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!in_ready && n < 100) begin
        step();
        n++;
      end
      step();
      if (prev >= 0) check("t6_spacing", 64'(cyc - prev), 64'(DW + 3));
      prev    = cyc;
      in_data = 32'($urandom);
    end
    in_valid = 1'b0;
    wait_idle("t6_idle");

    for (int i = 0; i < 6; i++) run_op(32'($urandom));

    step();
    step();
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
